// File: rtl/serial_word_deframer_if.sv
// rtl/serial_word_deframer_if.sv - bit-in / word-out handshake bundle for serial_word_deframer
//
// Purpose: groups the serial input, the buffered word output handshake and
// the frame status flags of serial_word_deframer.
// Ports (master = deframer side):
//   in_bit, in_valid      serial bit and its strobe from the shift stage
//   out_data, out_valid   head-of-buffer word and buffer non-empty
//   out_ready             consumer accepts the head word
//   sync_lock             deframer is inside a frame
//   frame_end             one-cycle pulse after the last word of a frame
//   overflow              sticky: a completed word was dropped
interface serial_word_deframer_if #(
    parameter int WIDTH = 8
);
    logic             in_bit;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sync_lock;
    logic             frame_end;
    logic             overflow;

    modport master (
        input  in_bit, in_valid, out_ready,
        output out_data, out_valid, sync_lock, frame_end, overflow
    );

    modport slave (
        output in_bit, in_valid, out_ready,
        input  out_data, out_valid, sync_lock, frame_end, overflow
    );
endinterface

// File: rtl/serial_word_deframer.sv
// rtl/serial_word_deframer.sv - sync-word hunting serial-to-word deframer with 2-entry output buffer
//
// Purpose: slides a WIDTH-bit window over the valid serial bits until it sees
// SYNC_WORD, then assembles the next FRAME_WORDS words MSB-first and pushes
// each into a 2-entry FIFO drained by a valid/ready handshake.
// Ports:
//   clk   clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   serial_word_deframer_if.master (in_bit/in_valid in,
//         out_data/out_valid/out_ready word handshake, sync_lock,
//         frame_end, overflow status)
module serial_word_deframer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(8'hA5),
    parameter int               FRAME_WORDS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_word_deframer_if.master bus
);
    localparam int HCW = $clog2(WIDTH + 1);
    localparam int BCW = $clog2(WIDTH);
    localparam int WCW = $clog2(FRAME_WORDS + 1);

    localparam logic [HCW-1:0] HUNT_SAT  = HCW'(WIDTH);
    localparam logic [HCW-1:0] HUNT_ARM  = HCW'(WIDTH - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] window_q;
    logic [WIDTH-1:0] window_d;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] word_d;
    logic [HCW-1:0]   hunt_cnt_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [WCW-1:0]   word_cnt_q;
    logic             sync_hit;
    logic             word_done;
    logic             frame_done;
    logic             frame_end_q;

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic             overflow_q;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             drop;

    always_comb begin
        state_d    = state_q;
        window_d   = {window_q[WIDTH-2:0], bus.in_bit};
        word_d     = {asm_q[WIDTH-2:0], bus.in_bit};
        sync_hit   = 1'b0;
        word_done  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            HUNT: begin
                // Only arm once a full window of fresh bits has been seen
                // since entering HUNT, so leftover window bits cannot match.
                if (bus.in_valid && hunt_cnt_q >= HUNT_ARM && window_d == SYNC_WORD) begin
                    sync_hit = 1'b1;
                    state_d  = LOCKED;
                end
            end
            LOCKED: begin
                if (bus.in_valid && bit_cnt_q == BIT_LAST) begin
                    word_done = 1'b1;
                    if (word_cnt_q == WORD_LAST) begin
                        frame_done = 1'b1;
                        state_d    = HUNT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            window_q    <= '0;
            asm_q       <= '0;
            hunt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_end_q <= frame_done;
            if (bus.in_valid) begin
                case (state_q)
                    HUNT: begin
                        window_q <= window_d;
                        if (hunt_cnt_q != HUNT_SAT) begin
                            hunt_cnt_q <= hunt_cnt_q + HCW'(1);
                        end
                        if (sync_hit) begin
                            bit_cnt_q  <= '0;
                            word_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        asm_q <= word_d;
                        if (word_done) begin
                            bit_cnt_q <= '0;
                            if (frame_done) begin
                                word_cnt_q <= '0;
                                hunt_cnt_q <= '0;
                            end else begin
                                word_cnt_q <= word_cnt_q + WCW'(1);
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Output buffer. A full buffer still accepts a word if the head leaves
    // on the same edge; otherwise the word is dropped and flagged.
    assign full    = (count_q == 2'd2);
    assign pop     = (count_q != 2'd0) && bus.out_ready;
    assign push_ok = word_done && (!full || pop);
    assign drop    = word_done && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= word_d;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // When empty, the slot behind the read pointer is the last word popped
    // (zero after reset), so out_data keeps showing it.
    assign bus.out_data  = (count_q == 2'd0) ? mem_q[~rd_ptr_q] : mem_q[rd_ptr_q];
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.sync_lock = (state_q == LOCKED);
    assign bus.frame_end = frame_end_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_word_deframer.sv
// tb/tb_serial_word_deframer.sv - scoreboard bench for serial_word_deframer
module tb_serial_word_deframer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_word_deframer_if #(.WIDTH(8)) m_if ();
    serial_word_deframer_if #(.WIDTH(8)) b_if ();

    serial_word_deframer #(.WIDTH(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(2)) u_main (
        .clk (clk),
        .rst (rst),
        .bus (m_if.master)
    );

    serial_word_deframer #(.WIDTH(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(4)) u_bp (
        .clk (clk),
        .rst (rst),
        .bus (b_if.master)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_m[$];
    logic [7:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic extra(input string name, input logic [7:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want no word", name, act);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && m_if.out_valid === 1'b1 && m_if.out_ready === 1'b1) begin
            if (exp_m.size() == 0) extra("main_extra_word", m_if.out_data);
            else check("main_word", m_if.out_data, exp_m.pop_front());
        end
        if (rst === 1'b0 && b_if.out_valid === 1'b1 && b_if.out_ready === 1'b1) begin
            if (exp_b.size() == 0) extra("bp_extra_word", b_if.out_data);
            else check("bp_word", b_if.out_data, exp_b.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        m_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b, input bit bp);
        if (bp) begin
            b_if.in_bit   = b;
            b_if.in_valid = 1'b1;
        end else begin
            m_if.in_bit   = b;
            m_if.in_valid = 1'b1;
        end
        step();
        m_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit bp, input bit gated);
        for (int i = 7; i >= 0; i--) begin
            if (gated && (i % 2 == 1)) idle(2);
            send_bit(v[i], bp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_m_valid"}, m_if.out_valid, 0);
        check({tag, "_m_data"}, m_if.out_data, 0);
        check({tag, "_m_lock"}, m_if.sync_lock, 0);
        check({tag, "_m_fend"}, m_if.frame_end, 0);
        check({tag, "_m_ovf"}, m_if.overflow, 0);
        check({tag, "_b_valid"}, b_if.out_valid, 0);
        check({tag, "_b_lock"}, b_if.sync_lock, 0);
        check({tag, "_b_ovf"}, b_if.overflow, 0);
    endtask

    task automatic run_frame(input bit gated, input string tag);
        exp_m.push_back(8'h3C);
        exp_m.push_back(8'hC3);
        send_byte(8'hA5, 1'b0, gated);
        check({tag, "_lock"}, m_if.sync_lock, 1);
        send_byte(8'h3C, 1'b0, gated);
        check({tag, "_valid_3c"}, m_if.out_valid, 1);
        check({tag, "_data_3c"}, m_if.out_data, 8'h3C);
        send_byte(8'hC3, 1'b0, gated);
        check({tag, "_valid_c3"}, m_if.out_valid, 1);
        check({tag, "_unlock"}, m_if.sync_lock, 0);
        check({tag, "_fend"}, m_if.frame_end, 1);
        idle(1);
        check({tag, "_fend_low"}, m_if.frame_end, 0);
        check({tag, "_ovf"}, m_if.overflow, 0);
        check({tag, "_drained"}, m_if.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        rst = 1'b1;
        m_if.in_bit = 1'b0; m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
        b_if.in_bit = 1'b0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;

        // reset with random serial activity
        for (int c = 0; c < 3; c++) begin
            m_if.in_bit   = 1'($urandom_range(1));
            m_if.in_valid = 1'($urandom_range(1));
            b_if.in_bit   = 1'($urandom_range(1));
            b_if.in_valid = 1'($urandom_range(1));
            step();
            check_quiet("rst");
        end
        rst = 1'b0;
        idle(1);
        check_quiet("rel");

        run_frame(1'b0, "cont");
        run_frame(1'b1, "gated");

        // sliding sync: 1111 then A5 locks only on bit 12
        exp_m.push_back(8'h11);
        exp_m.push_back(8'h22);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        v = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], 1'b0);
            if (i == 1) check("slide_early", m_if.sync_lock, 0);
            if (i == 0) check("slide_lock", m_if.sync_lock, 1);
        end
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        check("slide_fend", m_if.frame_end, 1);
        idle(2);

        // backpressure, buffer fills then drops
        exp_b.push_back(8'h01);
        exp_b.push_back(8'h02);
        send_byte(8'hA5, 1'b1, 1'b0);
        check("bp_lock", b_if.sync_lock, 1);
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        check("bp_full_ovf", b_if.overflow, 0);
        check("bp_full_head", b_if.out_data, 8'h01);
        send_byte(8'h03, 1'b1, 1'b0);
        check("bp_drop_ovf", b_if.overflow, 1);
        check("bp_drop_head", b_if.out_data, 8'h01);
        send_byte(8'h04, 1'b1, 1'b0);
        check("bp_fend", b_if.frame_end, 1);
        check("bp_unlock", b_if.sync_lock, 0);
        b_if.out_ready = 1'b1;
        idle(4);
        check("bp_drained", b_if.out_valid, 0);
        check("bp_sticky", b_if.overflow, 1);

        rst = 1'b1;
        step();
        check("bp_rst_ovf", b_if.overflow, 0);
        rst = 1'b0;
        idle(1);

        // push and pop on the same edge at full: no overflow
        b_if.out_ready = 1'b0;
        exp_b.push_back(8'h01);
        exp_b.push_back(8'h02);
        exp_b.push_back(8'h03);
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        v = 8'h03;
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b1);
        b_if.out_ready = 1'b1;
        send_bit(v[0], 1'b1);
        b_if.out_ready = 1'b0;
        check("bp_sim_ovf", b_if.overflow, 0);
        check("bp_sim_valid", b_if.out_valid, 1);
        check("bp_sim_head", b_if.out_data, 8'h02);
        send_byte(8'h04, 1'b1, 1'b0);
        check("bp_sim_drop_ovf", b_if.overflow, 1);
        check("bp_sim_fend", b_if.frame_end, 1);
        b_if.out_ready = 1'b1;
        idle(4);
        check("bp_sim_drained", b_if.out_valid, 0);

        // reset in the middle of a data word
        send_byte(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        step();
        check("mid_rst_lock", m_if.sync_lock, 0);
        check("mid_rst_valid", m_if.out_valid, 0);
        rst = 1'b0;
        idle(1);
        exp_m.push_back(8'h55);
        exp_m.push_back(8'hAA);
        send_byte(8'hA5, 1'b0, 1'b0);
        check("mid_relock", m_if.sync_lock, 1);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        check("mid_fend", m_if.frame_end, 1);
        idle(3);

        check("main_queue_left", exp_m.size(), 0);
        check("bp_queue_left", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
